// File: rtl/matrix_link_pkg.sv
// matrix_link_pkg: constants and FSM encoding shared by the serial
// matrix link transmitter and receiver.
package matrix_link_pkg;

   localparam int LINK_DATA_W     = 8;
   localparam int LINK_NUM_ELEMS  = 16;
   localparam int LINK_CLK_DIV    = 4;
   localparam int LINK_GAP_BITS   = 2;
   localparam int LINK_FRAME_BITS = LINK_DATA_W * LINK_NUM_ELEMS;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } link_state_t;

endpackage

// File: rtl/ser_bit_timer.sv
// ser_bit_timer: bit-period divider for the serial link.
// Ports: clk, rst (sync, active-high), enable (run during the next
// cycle), phase (registered ser_clk: low first half, high second half),
// bit_end (strobe in the last cycle of each bit period).
module ser_bit_timer
   import matrix_link_pkg::*;
#(
   parameter int CLK_DIV = LINK_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic phase,
   output logic bit_end
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic          run;

   assign bit_end = run && (cnt == LAST);

   // The first enabled cycle starts a fresh period at count 0.
   always_comb begin
      cnt_n = '0;
      if (run && (cnt != LAST)) cnt_n = cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         cnt   <= '0;
         phase <= 1'b0;
         run   <= 1'b0;
      end else begin
         cnt   <= cnt_n;
         phase <= (cnt_n >= HALF);
         run   <= 1'b1;
      end
   end

endmodule

// File: rtl/matrix_serial_tx.sv
// matrix_serial_tx: buffers one matrix from a valid/ready word stream,
// then sends it MSB first on a three-wire link with a trailing gap.
// Ports: clk, rst (sync, active-high); s_valid/s_ready/s_data word
// input; ser_data/ser_clk/ser_fsync link; busy (SEND or GAP) and
// frame_done (one-cycle pulse at the first GAP cycle).
module matrix_serial_tx
   import matrix_link_pkg::*;
#(
   parameter int DATA_W    = LINK_DATA_W,
   parameter int NUM_ELEMS = LINK_NUM_ELEMS,
   parameter int CLK_DIV   = LINK_CLK_DIV,
   parameter int GAP_BITS  = LINK_GAP_BITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              ser_data,
   output logic              ser_clk,
   output logic              ser_fsync,
   output logic              busy,
   output logic              frame_done
);

   localparam int CNT_W   = $clog2(NUM_ELEMS + 1);
   localparam int EL_W    = $clog2(NUM_ELEMS);
   localparam int BIT_W   = $clog2(DATA_W);
   localparam int GAP_LEN = GAP_BITS * CLK_DIV;
   localparam int GAP_W   = $clog2(GAP_LEN);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ELEMS - 1);
   localparam logic [EL_W-1:0]  EL_LAST  = EL_W'(NUM_ELEMS - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

   link_state_t       state, state_n;
   logic [CNT_W-1:0]  count, count_n;
   logic [EL_W-1:0]   elem, elem_n;
   logic [BIT_W-1:0]  bit_idx, bit_n;
   logic [GAP_W-1:0]  gap, gap_n;
   logic [DATA_W-1:0] shreg, sh_n;
   logic              data_n, fsync_n, done_n;
   logic              wr;
   logic              bit_end;
   logic [DATA_W-1:0] first, nxt;

   logic [DATA_W-1:0] mem [NUM_ELEMS];

   // Element 0 comes straight from the input if it is also the last word.
   assign first = (count == '0) ? s_data : mem[0];
   assign nxt   = mem[elem + 1'b1];

   ser_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .enable  (state_n == SEND),
      .phase   (ser_clk),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk) begin
      if (wr) mem[count[EL_W-1:0]] <= s_data;
   end

   always_comb begin
      state_n = state;
      count_n = count;
      elem_n  = elem;
      bit_n   = bit_idx;
      gap_n   = gap;
      sh_n    = shreg;
      data_n  = ser_data;
      fsync_n = ser_fsync;
      done_n  = 1'b0;
      wr      = 1'b0;
      unique case (state)
         FILL: begin
            if (s_valid && s_ready) begin
               wr = 1'b1;
               if (count == CNT_LAST) begin
                  state_n = SEND;
                  count_n = '0;
                  elem_n  = '0;
                  bit_n   = '0;
                  data_n  = first[DATA_W-1];
                  sh_n    = {first[DATA_W-2:0], 1'b0};
                  fsync_n = 1'b1;
               end else begin
                  count_n = count + 1'b1;
               end
            end
         end
         SEND: begin
            if (bit_end) begin
               fsync_n = 1'b0;
               if (elem == EL_LAST && bit_idx == BIT_LAST) begin
                  state_n = GAP;
                  done_n  = 1'b1;
                  data_n  = 1'b0;
                  gap_n   = '0;
               end else if (bit_idx == BIT_LAST) begin
                  elem_n = elem + 1'b1;
                  bit_n  = '0;
                  data_n = nxt[DATA_W-1];
                  sh_n   = {nxt[DATA_W-2:0], 1'b0};
               end else begin
                  bit_n  = bit_idx + 1'b1;
                  data_n = shreg[DATA_W-1];
                  sh_n   = {shreg[DATA_W-2:0], 1'b0};
               end
            end
         end
         GAP: begin
            if (gap == GAP_LAST) begin
               state_n = FILL;
               count_n = '0;
            end else begin
               gap_n = gap + 1'b1;
            end
         end
         default: state_n = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         count      <= '0;
         elem       <= '0;
         bit_idx    <= '0;
         gap        <= '0;
         shreg      <= '0;
         s_ready    <= 1'b0;
         ser_data   <= 1'b0;
         ser_fsync  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         elem       <= elem_n;
         bit_idx    <= bit_n;
         gap        <= gap_n;
         shreg      <= sh_n;
         s_ready    <= (state_n == FILL);
         ser_data   <= data_n;
         ser_fsync  <= fsync_n;
         busy       <= (state_n != FILL);
         frame_done <= done_n;
      end
   end

endmodule

// File: doc/matrix_serial_tx.md
Name: matrix_serial_tx

Overview:
Host-side serial transmitter that loads one 4x4 operand matrix through a valid/ready word interface. It buffers the matrix and then drives the three-wire link (serial data, serial clock, frame sync) consumed by the accelerator's A/B serial inputs. One instance is used per operand (A, B). It is also used as the stimulus driver in system benches.

Parameters:
DATA_W, 8, bits per matrix element
NUM_ELEMS, 16, elements per frame (row-major, element 0 = row0 col0)
CLK_DIV, 4, clk cycles per serial bit; even, >=2
GAP_BITS, 2, idle bit periods enforced after each frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
s_valid  in  1  input word valid
s_ready  out  1  block accepts word this cycle
s_data  in  DATA_W  matrix element
ser_data  out  1  serial data, MSB first
ser_clk  out  1  serial clock
ser_fsync  out  1  frame sync
busy  out  1  high in SEND or GAP
frame_done  out  1  one-cycle pulse at end of frame

Interface rule (already decided): one clock, clk; reset is rst, synchronous and active-high.

Behaviour:
- All outputs are registered. Reset values: s_ready=0 during the reset cycle and 1 afterwards (in FILL). ser_data=0, ser_clk=0, ser_fsync=0, busy=0, frame_done=0.
- On reset: state=FILL, word count=0, bit/divider counters=0. Buffer contents are don't-care.
- FILL state:
  - s_ready=1.
  - A handshake (s_valid&&s_ready) writes s_data to buf[count] and increments count.
  - The handshake that brings count to NUM_ELEMS moves the state to SEND in the next cycle. s_ready drops the cycle after that handshake.
  - s_valid gaps are permitted; they only stall the fill.
- SEND state:
  - If the last handshake occurs at cycle T, then at T+1: ser_data=buf[0][DATA_W-1], ser_fsync=1, ser_clk=0.
  - Each bit period is CLK_DIV cycles. ser_clk is 0 for the first CLK_DIV/2 cycles and 1 for the second half.
  - ser_data and ser_fsync change only at period start (falling edge of ser_clk). The receiver samples on the rising edge.
  - ser_fsync is high for bit 0 of the frame only.
  - Bit order: element 0 to NUM_ELEMS-1, each MSB to LSB. Total NUM_ELEMS*DATA_W bits (128 at default) = 512 clk cycles at default.
  - s_ready=0 and busy=1. The buffer is read-only.
- GAP state:
  - Entered after the last bit period completes. frame_done=1 for exactly that first GAP cycle.
  - ser_clk=0, ser_data=0, ser_fsync=0 for GAP_BITS*CLK_DIV cycles. No ser_clk edges occur.
  - Then the state returns to FILL: count=0, s_ready=1.
- Single buffer: no overlap of fill and send. Throughput is one frame per (NUM_ELEMS fill cycles minimum + frame + gap).
- Reset mid-SEND or mid-GAP:
  - The next cycle shows reset values.
  - The partial frame is abandoned and no frame_done is issued.
  - Receivers resynchronise on the next ser_fsync.
- s_valid asserted during SEND/GAP is ignored (no handshake); data is held by the source.
- Counter widths: $clog2 of the respective range, with no wrap inside a frame. The element index saturates conceptually at NUM_ELEMS-1; the bit index wraps DATA_W-1 to 0 per element.

Decomposition:
- Shared package matrix_link_pkg holds:
  - LINK_DATA_W=8
  - LINK_NUM_ELEMS=16
  - state enum FILL/SEND/GAP (2-bit encoding)
  - bit-period constants
  These are shared with the receive side.
- One sub-module: ser_bit_timer.
  - Input: enable.
  - Outputs: ser_clk phase and a bit_start/bit_end strobe every CLK_DIV cycles.
  - The top FSM and shift register stay in matrix_serial_tx.

Test Plan:
- Reset then idle 20 cycles -> s_ready=1 from the cycle after reset. ser_clk/ser_data/ser_fsync/busy/frame_done all 0 and no ser_clk edges.
- Back-to-back load 0x01..0x10, CLK_DIV=4:
  - Exactly 128 ser_clk rising edges.
  - ser_fsync high only across the first bit.
  - Rising-edge-sampled bits reconstruct 0x01..0x10 MSB first.
  - frame_done pulses once, 513 cycles after the last handshake.
  - s_ready returns after 8 further gap cycles.
- Load with s_valid toggling every other cycle, data 0xA5 repeated -> identical serial content (0xA5 x16). SEND starts only the cycle after the 16th handshake.
- s_valid held high through SEND with changing s_data -> no extra handshakes. The transmitted frame is unchanged. The next frame takes the first 16 words offered after GAP.
- rst asserted mid-frame at bit 40 -> all outputs 0 next cycle, no frame_done, count=0. A fresh 16-word load transmits correctly.
- CLK_DIV=2, DATA_W=8 with 0xFF,0x00 alternating -> ser_clk toggles every cycle during SEND. Data transitions are aligned to falling edges. Frame length is 256 cycles.
